// File: rtl/fsk_pkg.sv
// Shared definitions for the FSK symbol decoder: FSM encodings, bit-decision codes,
// bit-period overhead constants and the energy/tie decision helper.
package fsk_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CLEAR_AN  = 3'd1,
    INTEGRATE = 3'd2,
    SETTLE    = 3'd3,
    DECIDE    = 3'd4
  } fsk_state_t;

  typedef enum logic [1:0] {
    BIT0    = 2'd0,
    BIT1    = 2'd1,
    ERASURE = 2'd2
  } fsk_decision_t;

  localparam int SETTLE_CYCLES   = 2;
  // CLEAR_AN (1) + SETTLE (2) + DECIDE (1) cycles outside the integration window.
  localparam int OVERHEAD_CYCLES = 4;

  // The 33-bit sum cannot overflow, so a saturated analyzer still reads as high energy.
  function automatic fsk_decision_t decide_bit(input logic [31:0] f0,
                                               input logic [31:0] f1,
                                               input logic [32:0] thresh);
    logic [32:0] sum;
    sum = {1'b0, f0} + {1'b0, f1};
    if ((sum < thresh) || (f0 == f1)) return ERASURE;
    else if (f1 > f0) return BIT1;
    else return BIT0;
  endfunction

endpackage

// File: rtl/fsk_bit_timer.sv
// Loadable down-counter; expired is high while the count sits at zero, so loading
// N-1 makes expired rise on the Nth cycle after the load edge.
module fsk_bit_timer #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/fsk_symbol_decoder.sv
// FSK bit slicer: sequences the frequency analyzer once per bit period, decides bits,
// packs them LSB-first into words. FSK_SYMBOL_DECODER_STATS_EN adds erasure/word stats.
module fsk_symbol_decoder
  import fsk_pkg::*;
#(
  parameter int CLOCK_FREQUENCY    = 50000000,
  parameter int BIT_RATE           = 1000,
  parameter int MIN_ENERGY_PERCENT = 50,
  parameter int BITS_PER_WORD      = 8
) (
  input  logic                     clock,
  input  logic                     clear,
  input  logic                     start,
  input  logic                     stop,
  input  logic [31:0]              f0_value,
  input  logic [31:0]              f1_value,
  input  logic [31:0]              unknown,
  output logic                     analyzer_enable,
  output logic                     analyzer_clear,
  output logic [BITS_PER_WORD-1:0] word_data,
  output logic                     word_valid,
  input  logic                     word_ready,
  output logic                     word_overrun,
  output logic                     symbol_error,
  output logic                     busy,
`ifdef FSK_SYMBOL_DECODER_STATS_EN
  output logic [15:0]              erasure_count,
  output logic [15:0]              word_count,
  output logic [0:0]               unknown_ratio_flag,
`endif
  output logic [2:0]               debug_state
);

  // BIT_TICKS must be >= 8 so the integration window is at least 4 cycles long.
  localparam int BIT_TICKS       = CLOCK_FREQUENCY / BIT_RATE;
  localparam int INTEGRATE_TICKS = BIT_TICKS - OVERHEAD_CYCLES;
  localparam int THRESH          = INTEGRATE_TICKS * MIN_ENERGY_PERCENT / 100;
  localparam int CW              = 6;

  fsk_state_t               state, next_state;
  fsk_decision_t            decision;
  logic                     timer_load, timer_expired;
  logic [31:0]              timer_value;
  logic                     stop_pending, stop_now;
  logic [CW-1:0]            bit_count, count_next;
  logic [BITS_PER_WORD-1:0] shift_reg, shift_next;
  logic                     word_done, word_load;

  fsk_bit_timer #(.WIDTH(32)) u_timer (
    .clock      (clock),
    .clear      (clear),
    .load       (timer_load),
    .load_value (timer_value),
    .expired    (timer_expired)
  );

  assign decision    = decide_bit(f0_value, f1_value, 33'(THRESH));
  assign stop_now    = stop_pending | stop;
  assign debug_state = state;

  always_comb begin
    shift_next = shift_reg;
    count_next = bit_count;
    if (decision != ERASURE) begin
      shift_next = shift_reg | (BITS_PER_WORD'(decision == BIT1) << bit_count);
      count_next = bit_count + 1'b1;
    end
  end

  assign word_done = (state == DECIDE) && (decision != ERASURE) &&
                     (count_next == CW'(BITS_PER_WORD));
  assign word_load = word_done && (!word_valid || word_ready);

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state  = state;
    timer_load  = 1'b0;
    timer_value = '0;
    case (state)
      IDLE:      if (start) next_state = CLEAR_AN;
      CLEAR_AN: begin
        next_state  = INTEGRATE;
        timer_load  = 1'b1;
        timer_value = 32'(INTEGRATE_TICKS - 1);
      end
      INTEGRATE: if (timer_expired) begin
        next_state  = SETTLE;
        timer_load  = 1'b1;
        timer_value = 32'(SETTLE_CYCLES - 1);
      end
      SETTLE:    if (timer_expired) next_state = DECIDE;
      DECIDE:    next_state = stop_now ? IDLE : CLEAR_AN;
      default:   next_state = IDLE;
    endcase
  end

  // Analyzer clear stays released through SETTLE/DECIDE so its counts survive until sampled.
  always_comb begin
    analyzer_clear  = 1'b0;
    analyzer_enable = 1'b0;
    symbol_error    = 1'b0;
    busy            = (state != IDLE);
    case (state)
      INTEGRATE: begin
        analyzer_clear  = 1'b1;
        analyzer_enable = 1'b1;
      end
      SETTLE:    analyzer_clear = 1'b1;
      DECIDE: begin
        analyzer_clear = 1'b1;
        symbol_error   = (decision == ERASURE);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      word_data    <= '0;
      word_valid   <= 1'b0;
      word_overrun <= 1'b0;
      stop_pending <= 1'b0;
      bit_count    <= '0;
      shift_reg    <= '0;
    end else begin
      if (word_valid && word_ready) word_valid <= 1'b0;
      if (state == IDLE) begin
        stop_pending <= 1'b0;
        if (start) begin
          word_overrun <= 1'b0;
          bit_count    <= '0;
          shift_reg    <= '0;
        end
      end else if (stop) begin
        stop_pending <= 1'b1;
      end
      if (state == DECIDE) begin
        if (decision == ERASURE) begin
          bit_count <= '0;
          shift_reg <= '0;
        end else if (word_done) begin
          bit_count <= '0;
          shift_reg <= '0;
          if (word_load) begin
            word_data  <= shift_next;
            word_valid <= 1'b1;
          end else begin
            word_overrun <= 1'b1;
          end
        end else begin
          bit_count <= count_next;
          shift_reg <= shift_next;
        end
        // Stopping discards the partial word.
        if (stop_now) begin
          bit_count    <= '0;
          shift_reg    <= '0;
          stop_pending <= 1'b0;
        end
      end
    end
  end

`ifdef FSK_SYMBOL_DECODER_STATS_EN
  logic [32:0] energy_sum;
  assign energy_sum = {1'b0, f0_value} + {1'b0, f1_value};

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      erasure_count      <= '0;
      word_count         <= '0;
      unknown_ratio_flag <= '0;
    end else if ((state == IDLE) && start) begin
      erasure_count <= '0;
      word_count    <= '0;
    end else if (state == DECIDE) begin
      if ((decision == ERASURE) && (erasure_count != 16'hFFFF))
        erasure_count <= erasure_count + 16'd1;
      if (word_load && (word_count != 16'hFFFF))
        word_count <= word_count + 16'd1;
      unknown_ratio_flag <= ({1'b0, unknown} > energy_sum);
    end
  end
`else
  logic unused_unknown;
  assign unused_unknown = ^unknown;
`endif

endmodule
